uart_tx_core: RTL and testbench

//  Serialises bytes from the peripheral bus side onto the UART line tx_o.
//  It is the transmit half of the UART controller, sitting next to the RX path that

---
 rtl/uart_tx_core.sv | 145 ++++++++++++++
 tb/tb_uart_tx_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmit core: serialises one byte per request as start, 8 data bits LSB-first,
// optional even parity and one or two stop bits, with a runtime clocks-per-bit divisor.
module uart_tx_core #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_valid_i,
    input  logic [7:0]       tx_data_i,
    input  logic             parity_en_i,
    input  logic             stopbit_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             tx_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } stateT;

    stateT             state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              parEn_q, parEn_d;
    logic              stop2_q, stop2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  baudCnt_q, baudCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bitEnd;

    // The whole frame configuration is snapshotted at accept so later input changes are harmless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            data_q    <= '0;
            parEn_q   <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parEn_q   <= parEn_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign bitEnd = (baudCnt_q == div_q - DIV_W'(1));

    // tx_d is the line level for the next cycle, so each transition loads the next bit's value.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parEn_d   = parEn_q;
        stop2_d   = stop2_q;
        div_d     = div_q;
        bitIdx_d  = bitIdx_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        baudCnt_d = bitEnd ? '0 : baudCnt_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                baudCnt_d = '0;
                bitIdx_d  = '0;
                if (tx_valid_i) begin
                    data_d  = tx_data_i;
                    parEn_d = parity_en_i;
                    stop2_d = stopbit_i;
                    div_d   = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    tx_d     = data_q[0];
                    bitIdx_d = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
                        if (parEn_q) begin
                            state_d = PARITY;
                            tx_d    = ^data_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        tx_d     = data_q[bitIdx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d  = STOP;
                    tx_d     = 1'b1;
                    bitIdx_d = '0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                // bitIdx counts stop bits so a two-stop frame reuses the same baud period logic.
                if (bitEnd) begin
                    if (stop2_q && (bitIdx_q == 3'd0)) begin
                        bitIdx_d = 3'd1;
                    end else begin
                        state_d  = IDLE;
                        bitIdx_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: each frame is compared bit by bit against
// hand-written line patterns, including timing, done/busy behaviour and reset abort.
module tb_uart_tx_core;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        parity_en_i = 1'b0;
    logic        stopbit_i = 1'b0;
    logic [15:0] baud_div_i = 16'd1;
    logic        busy_o;
    logic        done_o;
    logic        tx_o;

    int compared = 0;
    int mismatched = 0;

    uart_tx_core #(.DIV_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tx_valid_i  (tx_valid_i),
        .tx_data_i   (tx_data_i),
        .parity_en_i (parity_en_i),
        .stopbit_i   (stopbit_i),
        .baud_div_i  (baud_div_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tx_o        (tx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a request and returns #1 after the edge that accepts it.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop2,
                                 input logic [15:0] div, input bit hold);
        tx_data_i   = data;
        parity_en_i = par;
        stopbit_i   = stop2;
        baud_div_i  = div;
        tx_valid_i  = 1'b1;
        nextCycle();
        if (!hold) tx_valid_i = 1'b0;
    endtask

    // Follows a frame starting in the first start-bit cycle; bits[0] is sent first.
    // At corruptAt the inputs are scrambled and a spurious request is made.
    // Returns in the cycle right after the last stop bit.
    task automatic checkFrame(input string tag, input logic [11:0] bits, input int nbits,
                              input int div, input int corruptAt);
        int match;
        int busyCnt = 0;
        int doneCnt = 0;
        int cyc;
        for (int b = 0; b < nbits; b++) begin
            match = 0;
            for (int c = 0; c < div; c++) begin
                cyc = b * div + c;
                if (cyc == corruptAt) begin
                    tx_data_i   = 8'hFF;
                    parity_en_i = 1'b1;
                    stopbit_i   = 1'b1;
                    baud_div_i  = 16'd1;
                    tx_valid_i  = 1'b1;
                end
                if (corruptAt >= 0 && cyc == corruptAt + 1) tx_valid_i = 1'b0;
                if (tx_o === bits[b]) match++;
                if (busy_o === 1'b1) busyCnt++;
                if (done_o !== 1'b0) doneCnt++;
                nextCycle();
            end
            checkOutput($sformatf("%s bit%0d cycles", tag, b), match, div);
        end
        checkOutput({tag, " busy cycles"}, busyCnt, nbits * div);
        checkOutput({tag, " early done"}, doneCnt, 0);
        checkOutput({tag, " done pulse"}, int'(done_o), 1);
        checkOutput({tag, " busy at end"}, int'(busy_o), 0);
        checkOutput({tag, " line idle"}, int'(tx_o), 1);
    endtask

    initial begin
        int doneSeen;

        // Test 1: async reset asserted between edges.
        #3 rst_i = 1'b1;
        #1;
        checkOutput("reset tx", int'(tx_o), 1);
        checkOutput("reset busy", int'(busy_o), 0);
        checkOutput("reset done", int'(done_o), 0);
        repeat (2) nextCycle();
        rst_i = 1'b0;
        nextCycle();
        checkOutput("post-reset busy", int'(busy_o), 0);

        // Test 2: 0x1C, parity, two stops, DIV=868 (12 bits).
        applyStimulus(8'h1C, 1'b1, 1'b1, 16'd868, 1'b0);
        checkFrame("t2 1C", 12'b1110_0011_1000, 12, 868, -1);
        nextCycle();
        checkOutput("t2 done width", int'(done_o), 0);

        // Test 3: 0x0D, DIV=4, inputs disturbed mid-frame.
        applyStimulus(8'h0D, 1'b0, 1'b0, 16'd4, 1'b0);
        checkFrame("t3 0D", 12'b00_10_0001_1010, 10, 4, 13);
        nextCycle();
        checkOutput("t3 no queued frame", int'(busy_o), 0);

        // Test 4: 0x7F twice, valid held, parity on.
        applyStimulus(8'h7F, 1'b1, 1'b0, 16'd4, 1'b1);
        checkFrame("t4 7F#1", 12'b0_110_1111_1110, 11, 4, -1);
        nextCycle();
        tx_valid_i = 1'b0;
        checkFrame("t4 7F#2", 12'b0_110_1111_1110, 11, 4, -1);
        nextCycle();
        checkOutput("t4 idle after", int'(busy_o), 0);

        // Test 5: DIV=0 behaves as one clock per bit.
        applyStimulus(8'hA5, 1'b0, 1'b0, 16'd0, 1'b0);
        checkFrame("t5 A5", 12'b00_11_0100_1010, 10, 1, -1);
        nextCycle();

        // Test 6: reset during data bit 3 of 0x55, then a clean frame.
        applyStimulus(8'h55, 1'b0, 1'b0, 16'd4, 1'b0);
        repeat (18) nextCycle();
        checkOutput("t6 line before abort", int'(tx_o), 0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("t6 abort tx", int'(tx_o), 1);
        checkOutput("t6 abort busy", int'(busy_o), 0);
        doneSeen = 0;
        repeat (3) begin
            nextCycle();
            if (done_o !== 1'b0) doneSeen++;
        end
        rst_i = 1'b0;
        repeat (20) begin
            nextCycle();
            if (done_o !== 1'b0) doneSeen++;
        end
        checkOutput("t6 no done after abort", doneSeen, 0);
        checkOutput("t6 idle line", int'(tx_o), 1);
        applyStimulus(8'h55, 1'b0, 1'b0, 16'd4, 1'b0);
        checkFrame("t6 55", 12'b00_10_1010_1010, 10, 4, -1);
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
